sha3_capture_collector: RTL and testbench
=========================================

SHA3_CAPTURE_COLLECTOR -- requirements
Module: sha3_capture_collector

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-002 Parameter STORE_LANES, default 4, number of hash lanes kept per entry (lanes 0..STORE_LANES-1), range 1..25.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port capture  input  1  scanner result strobe; every cycle high is one candidate event.
REQ-006 Port nonce  input  32  nonce of the candidate, valid with capture.
REQ-007 Port hash  input  64 x 25  hash lanes of the candidate, valid with capture.
REQ-008 Port scan_count  input  32  scanner progress counter, sampled as entry timestamp.
REQ-009 Port pop  input  1  consumer acknowledges the head entry.
REQ-010 Port clear  input  1  synchronous flush of FIFO and statistics.
REQ-011 Port rvalid  output  1  FIFO non-empty; head entry outputs meaningful.
REQ-012 Port rnonce  output  32  head entry nonce.
REQ-013 Port rhash  output  64 x STORE_LANES  head entry hash lanes.
REQ-014 Port rstamp  output  32  head entry scan_count sample.
REQ-015 Port level  output  $clog2(DEPTH)+1  current entry count.
REQ-016 Port overflow  output  1  sticky: at least one event dropped since reset/clear.
REQ-017 Port dropped  output  16  saturating count of dropped events.
REQ-018 Port irq  output  1  one-cycle pulse when level goes 0 -> nonzero.

Function
REQ-019 Storage SHALL be a circular buffer with registered write pointer, read pointer and level counter; pointers wrap modulo DEPTH.
REQ-020 An event SHALL be accepted when capture=1, clear=0 and (level<DEPTH or pop accepted same cycle); entry = {nonce, hash[0..STORE_LANES-1], scan_count} sampled that cycle.
REQ-021 Accepted event at edge N SHALL be visible at the head (if FIFO was empty) from cycle N+1: rvalid=1, rnonce/rhash/rstamp = sampled values.
REQ-022 pop SHALL be accepted only when rvalid=1; pop with rvalid=0 SHALL be ignored with no state change.
REQ-023 Accepted pop SHALL advance read pointer; next head appears cycle after pop edge.
REQ-024 Simultaneous accepted capture and pop SHALL leave level unchanged; applies when full (write into slot freed by pop).
REQ-025 Capture with level=DEPTH and no pop SHALL drop the event: no storage change, overflow set, dropped incremented, saturating at 0xFFFF.
REQ-026 clear=1 SHALL, at next edge, zero pointers, level, overflow, dropped; any capture/pop that cycle SHALL be discarded and not counted.
REQ-027 irq SHALL be high for exactly the cycle after an edge where level went from 0 to nonzero; not asserted for clear or drop.
REQ-028 rnonce/rhash/rstamp when rvalid=0 SHALL hold last storage contents at read pointer; consumers SHALL ignore them.
REQ-029 level SHALL equal number of accepted captures minus accepted pops since reset/clear, never exceeding DEPTH.
REQ-030 Only hash lanes 0..STORE_LANES-1 SHALL be stored; remaining lanes unused.

Reset
REQ-031 rst_n=0 SHALL asynchronously force rvalid=0, level=0, overflow=0, dropped=0, irq=0, pointers=0.
REQ-032 Storage contents SHALL NOT need reset; rnonce/rhash/rstamp undefined until first accepted capture.
REQ-033 Reset asserted mid-operation SHALL discard all entries; first capture after rst_n rise behaves as into empty FIFO.
REQ-034 Inputs SHALL be ignored while rst_n=0.

Verification
REQ-035 Single event: capture with nonce=0x0000_1234, hash[0]=0xDEAD_BEEF_0000_0001, scan_count=100 -> next cycle rvalid=1, rnonce=0x1234, rhash[0] matches, rstamp=100, level=1, irq one pulse.
REQ-036 Fill and overflow (DEPTH=4): 6 consecutive captures nonce 1..6, no pop -> level=4, overflow=1, dropped=2; four pops read nonces 1,2,3,4 in order, then rvalid=0.
REQ-037 Full with concurrent pop+capture nonce=9 -> level stays 4, dropped unchanged, pop order ends ...,9.
REQ-038 Clear with concurrent capture while level=3, dropped=5 -> next cycle level=0, rvalid=0, overflow=0, dropped=0; captured nonce not stored.
REQ-039 Saturation: 70000 captures while full -> dropped=0xFFFF, overflow=1.
REQ-040 Async reset mid-stream with level=2 -> rvalid=0, level=0 immediately without clock edge; pop on empty after reset -> no change.

Source files
------------

// File: rtl/sha3_capture_collector.sv
// sha3_capture_collector
//   Collects scanner result events into a small circular FIFO. Each entry
//   holds the candidate nonce, the first STORE_LANES hash lanes and a
//   scan_count timestamp. The module also keeps a sticky overflow flag and a
//   saturating drop counter, and pulses irq when the FIFO goes from empty to
//   non-empty.
//
// Parameters
//   DEPTH        FIFO entries (power of two, 2..16)
//   STORE_LANES  hash lanes kept per entry (1..25)
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   capture      candidate strobe, one event per high cycle
//   nonce        candidate nonce (valid with capture)
//   hash         25 x 64-bit hash lanes (valid with capture)
//   scan_count   scanner progress, stored as the entry timestamp
//   pop          consumer acknowledges the head entry
//   clear        synchronous flush of FIFO and statistics
//   rvalid       FIFO non-empty
//   rnonce, rhash, rstamp   head entry contents
//   level        current entry count
//   overflow     sticky drop flag
//   dropped      saturating dropped-event count
//   irq          one-cycle pulse on the empty -> non-empty transition
module sha3_capture_collector #(
  parameter int DEPTH       = 4,
  parameter int STORE_LANES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capture,
  input  logic [31:0]                  nonce,
  input  logic [24:0][63:0]            hash,
  input  logic [31:0]                  scan_count,
  input  logic                         pop,
  input  logic                         clear,
  output logic                         rvalid,
  output logic [31:0]                  rnonce,
  output logic [STORE_LANES-1:0][63:0] rhash,
  output logic [31:0]                  rstamp,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic [15:0]                  dropped,
  output logic                         irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]                  mem_nonce [DEPTH];
  logic [STORE_LANES-1:0][63:0] mem_hash  [DEPTH];
  logic [31:0]                  mem_stamp [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic pop_acc;
  logic cap_acc;
  logic cap_drop;

  // Lanes above STORE_LANES are intentionally not stored.
  logic unused_hash;
  assign unused_hash = ^hash;

  assign rvalid = (level != '0);

  // A full FIFO still accepts a capture when the head is popped in the same
  // cycle: the write lands in the slot the pop frees.
  always_comb begin
    pop_acc  = 1'b0;
    cap_acc  = 1'b0;
    cap_drop = 1'b0;
    if (!clear) begin
      pop_acc  = pop && rvalid;
      cap_acc  = capture && ((level < LW'(DEPTH)) || pop_acc);
      cap_drop = capture && !cap_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
      irq      <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
      irq      <= 1'b0;
    end else begin
      if (cap_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc) rd_ptr <= rd_ptr + 1'b1;
      if (cap_acc && !pop_acc)      level <= level + 1'b1;
      else if (pop_acc && !cap_acc) level <= level - 1'b1;
      if (cap_drop) begin
        overflow <= 1'b1;
        if (dropped != 16'hFFFF) dropped <= dropped + 1'b1;
      end
      // When empty no pop can be accepted, so any capture makes level 1.
      irq <= cap_acc && (level == '0);
    end
  end

  // Storage needs no reset; the rst_n gate keeps it untouched during reset.
  always_ff @(posedge clk) begin
    if (rst_n && cap_acc) begin
      mem_nonce[wr_ptr] <= nonce;
      mem_hash[wr_ptr]  <= hash[STORE_LANES-1:0];
      mem_stamp[wr_ptr] <= scan_count;
    end
  end

  assign rnonce = mem_nonce[rd_ptr];
  assign rhash  = mem_hash[rd_ptr];
  assign rstamp = mem_stamp[rd_ptr];

endmodule

// File: tb/tb_sha3_capture_collector.sv
module tb_sha3_capture_collector;
  localparam int DEPTH = 4;
  localparam int SL    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic capture = 1'b0;
  logic pop = 1'b0;
  logic clear = 1'b0;
  logic [31:0] nonce = '0;
  logic [31:0] scan_count = '0;
  logic [24:0][63:0] hash = '0;

  logic rvalid;
  logic [31:0] rnonce;
  logic [SL-1:0][63:0] rhash;
  logic [31:0] rstamp;
  logic [2:0] level;
  logic overflow;
  logic [15:0] dropped;
  logic irq;

  sha3_capture_collector #(.DEPTH(DEPTH), .STORE_LANES(SL)) dut (
    .clk(clk), .rst_n(rst_n), .capture(capture), .nonce(nonce), .hash(hash),
    .scan_count(scan_count), .pop(pop), .clear(clear), .rvalid(rvalid),
    .rnonce(rnonce), .rhash(rhash), .rstamp(rstamp), .level(level),
    .overflow(overflow), .dropped(dropped), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]         n;
    logic [SL-1:0][63:0] h;
    logic [31:0]         s;
  } ent_t;

  ent_t        exp_q[$];
  int          m_level = 0;
  logic        m_over = 1'b0;
  logic [15:0] m_drop = '0;
  logic        m_irq = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of entries plus counters, updated per clock.
  bit   mp_ok, mc_ok;
  ent_t me;
  always @(posedge clk) begin
    if (rst_n) begin
      if (clear) begin
        exp_q.delete();
        m_level = 0;
        m_over  = 1'b0;
        m_drop  = '0;
        m_irq   = 1'b0;
      end else begin
        mp_ok = pop && (m_level > 0);
        mc_ok = capture && ((m_level < DEPTH) || mp_ok);
        m_irq = mc_ok && (m_level == 0);
        if (mp_ok) m_level--;
        if (mc_ok) begin
          me.n = nonce;
          for (int i = 0; i < SL; i++) me.h[i] = hash[i];
          me.s = scan_count;
          exp_q.push_back(me);
          m_level++;
        end else if (capture) begin
          m_over = 1'b1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    m_level = 0;
    m_over  = 1'b0;
    m_drop  = '0;
    m_irq   = 1'b0;
  end

  // Monitor: compares status every cycle and the head entry whenever valid.
  always @(negedge clk) begin
    if (rst_n) begin
      check("level", level, m_level);
      check("rvalid", rvalid, m_level != 0);
      check("overflow", overflow, m_over);
      check("dropped", dropped, m_drop);
      check("irq", irq, m_irq);
      if (m_level > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got empty queue expected %0d entries", m_level);
        end else begin
          check("rnonce", rnonce, exp_q[0].n);
          check("rstamp", rstamp, exp_q[0].s);
          for (int i = 0; i < SL; i++) check("rhash", rhash[i], exp_q[0].h[i]);
          if (pop && !clear) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit c, input bit p, input bit cl,
                      input logic [31:0] n, input logic [63:0] h0, input logic [31:0] s);
    capture = c;
    pop = p;
    clear = cl;
    nonce = n;
    scan_count = s;
    for (int i = 0; i < 25; i++) hash[i] = {$urandom, $urandom};
    hash[0] = h0;
    @(posedge clk);
    #1;
  endtask

  task automatic rstep(input bit c, input bit p, input bit cl, input logic [31:0] n);
    step(c, p, cl, n, {$urandom, $urandom}, $urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dropped", dropped, 0);
    check("rst_irq", irq, 0);
    rst_n = 1'b1;
    rstep(0, 0, 0, 0);

    // Single event
    step(1, 0, 0, 32'h0000_1234, 64'hDEAD_BEEF_0000_0001, 100);
    check("single_rvalid", rvalid, 1);
    check("single_rnonce", rnonce, 32'h1234);
    check("single_rhash0", rhash[0], 64'hDEAD_BEEF_0000_0001);
    check("single_rstamp", rstamp, 100);
    check("single_level", level, 1);
    check("single_irq", irq, 1);
    rstep(0, 0, 0, 0);
    check("single_irq_off", irq, 0);
    rstep(0, 1, 0, 0);
    check("single_empty", rvalid, 0);

    // Fill and overflow
    for (int k = 1; k <= 6; k++) rstep(1, 0, 0, k);
    check("fill_level", level, 4);
    check("fill_overflow", overflow, 1);
    check("fill_dropped", dropped, 2);
    for (int k = 1; k <= 4; k++) begin
      check("fill_order", rnonce, k);
      rstep(0, 1, 0, 0);
    end
    check("fill_drained", rvalid, 0);
    rstep(0, 1, 0, 0);
    check("pop_empty_level", level, 0);

    // Full with concurrent pop and capture
    for (int k = 5; k <= 8; k++) rstep(1, 0, 0, k);
    rstep(1, 1, 0, 9);
    check("full_pc_level", level, 4);
    check("full_pc_dropped", dropped, 2);
    for (int k = 6; k <= 9; k++) begin
      check("full_pc_order", rnonce, k);
      rstep(0, 1, 0, 0);
    end

    // Clear with concurrent capture, level 3, dropped 5
    rstep(0, 0, 1, 0);
    for (int k = 0; k < 9; k++) rstep(1, 0, 0, 32'h100 + k);
    rstep(0, 1, 0, 0);
    check("pre_clr_level", level, 3);
    check("pre_clr_dropped", dropped, 5);
    rstep(1, 0, 1, 32'hABCD);
    check("clr_level", level, 0);
    check("clr_rvalid", rvalid, 0);
    check("clr_overflow", overflow, 0);
    check("clr_dropped", dropped, 0);
    check("clr_irq", irq, 0);

    // Saturation
    for (int k = 0; k < 4; k++) rstep(1, 0, 0, k);
    for (int k = 0; k < 70000; k++) rstep(1, 0, 0, $urandom);
    check("sat_dropped", dropped, 16'hFFFF);
    check("sat_overflow", overflow, 1);
    rstep(0, 0, 1, 0);

    // Async reset mid-stream
    rstep(1, 0, 0, 32'h77);
    rstep(1, 0, 0, 32'h78);
    check("pre_rst_level", level, 2);
    rst_n = 1'b0;
    #1;
    check("arst_rvalid", rvalid, 0);
    check("arst_level", level, 0);
    capture = 1'b1;
    pop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("in_rst_level", level, 0);
    rst_n = 1'b1;
    rstep(0, 1, 0, 0);
    check("post_rst_pop_level", level, 0);
    check("post_rst_pop_rvalid", rvalid, 0);
    step(1, 0, 0, 32'h55, 64'h1, 7);
    check("post_rst_cap_level", level, 1);
    check("post_rst_cap_nonce", rnonce, 32'h55);

    // Randomized traffic
    for (int k = 0; k < 3000; k++)
      rstep($urandom_range(0, 1), $urandom_range(0, 1), ($urandom % 60) == 0, $urandom);
    rstep(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
